// File: rtl/spi_pkg.sv
// Shared definitions for the oversampled SPI I/O expander: SPI mode codes
// ({CPOL,CPHA}) and the frame FSM state encoding.
package spi_pkg;

   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   typedef enum logic [1:0] {
      ST_WAIT_IDLE = 2'd0,
      ST_IDLE      = 2'd1,
      ST_SHIFT     = 2'd2
   } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input followed by a registered
// rise/fall detector; the pulses are one clk wide.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;
   logic                   fall_q;

   // Resetting the chain to 0 means a line that is already high yields one rise
   // pulse after reset; the frame FSM relies on that to leave its wait state.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
         fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/spi_io_expander.sv
// System-clocked SPI slave I/O expander: all four SPI modes, daisy-chain
// pass-through, frame-length check with update/error strobes.
module spi_io_expander
   import spi_pkg::*;
#(
   parameter int                  IO_COUNT    = 8,
   parameter bit                  CPOL        = 1'b0,
   parameter bit                  CPHA        = 1'b0,
   parameter int                  SYNC_STAGES = 2,
   parameter logic [IO_COUNT-1:0] RST_VAL     = '0
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                sck_i,
   input  logic                nss_i,
   input  logic                sdi_i,
   output logic                sdo_o,
   output logic                sdo_oe_o,
   input  logic [IO_COUNT-1:0] data_i,
   output logic [IO_COUNT-1:0] data_o,
   output logic                update_o,
   output logic                err_o,
   output logic                busy_o
);

   localparam logic [1:0] MODE        = {CPOL, CPHA};
   localparam bit         LEAD_RISE   = !(MODE == SPI_MODE2 || MODE == SPI_MODE3);
   localparam bit         SAMPLE_LEAD = (MODE == SPI_MODE0 || MODE == SPI_MODE2);
   localparam int         CW          = $clog2(IO_COUNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(IO_COUNT - 1);

   logic sck_rise, sck_fall, nss_rise, nss_fall;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
      .clk_i (clk_i),
      .rstn_i(rstn_i),
      .d_i   (sck_i),
      .rise_o(sck_rise),
      .fall_o(sck_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_nss_sync (
      .clk_i (clk_i),
      .rstn_i(rstn_i),
      .d_i   (nss_i),
      .rise_o(nss_rise),
      .fall_o(nss_fall)
   );

   // One stage longer than the synchroniser so the data bit lines up with the
   // registered SCK edge pulse.
   logic [SYNC_STAGES:0] sdi_q;
   logic                 sdi_s;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) sdi_q <= '0;
      else         sdi_q <= {sdi_q[SYNC_STAGES-1:0], sdi_i};
   end

   assign sdi_s = sdi_q[SYNC_STAGES];

   state_e              state_q;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                any_q, any_d;
   logic                rxd_q;
   logic [IO_COUNT-1:0] rxsr_q, rxsr_d;
   logic [IO_COUNT-1:0] txsr_q;
   logic [IO_COUNT-1:0] data_q;
   logic                sdo_q, oe_q, upd_q, err_q, busy_q;
   logic                lead_ev, trail_ev, sample_ev, shift_ev;

   // With CPHA=1 the first leading edge precedes any sample, so it must not
   // shift: the MSB stays on the line for bit 0.
   always_comb begin
      lead_ev   = LEAD_RISE ? sck_rise : sck_fall;
      trail_ev  = LEAD_RISE ? sck_fall : sck_rise;
      sample_ev = (state_q == ST_SHIFT) && (SAMPLE_LEAD ? lead_ev : trail_ev);
      shift_ev  = (state_q == ST_SHIFT) && (SAMPLE_LEAD ? trail_ev : lead_ev)
                  && (SAMPLE_LEAD || any_q);
      rxsr_d    = rxsr_q;
      cnt_d     = cnt_q;
      any_d     = any_q;
      if (sample_ev) begin
         rxsr_d = {rxsr_q[IO_COUNT-2:0], sdi_s};
         cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
         any_d  = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= ST_WAIT_IDLE;
         cnt_q   <= '0;
         any_q   <= 1'b0;
         rxd_q   <= 1'b0;
         rxsr_q  <= '0;
         txsr_q  <= '0;
         data_q  <= RST_VAL;
         sdo_q   <= 1'b0;
         oe_q    <= 1'b0;
         upd_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         upd_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            ST_WAIT_IDLE: begin
               if (nss_rise) state_q <= ST_IDLE;
            end
            ST_IDLE: begin
               if (nss_fall) begin
                  state_q <= ST_SHIFT;
                  txsr_q  <= data_i;
                  cnt_q   <= '0;
                  any_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  oe_q    <= 1'b1;
                  sdo_q   <= data_i[IO_COUNT-1];
               end
            end
            ST_SHIFT: begin
               rxsr_q <= rxsr_d;
               cnt_q  <= cnt_d;
               any_q  <= any_d;
               if (sample_ev) rxd_q <= sdi_s;
               if (shift_ev) begin
                  txsr_q <= {txsr_q[IO_COUNT-2:0], rxd_q};
                  sdo_q  <= txsr_q[IO_COUNT-2];
               end
               // The frame check uses the _d values so an edge landing in the
               // same clk as NSS rise still counts.
               if (nss_rise) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  oe_q    <= 1'b0;
                  sdo_q   <= 1'b0;
                  if (any_d && cnt_d == '0) begin
                     data_q <= rxsr_d;
                     upd_q  <= 1'b1;
                  end else if (any_d) begin
                     err_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_WAIT_IDLE;
         endcase
      end
   end

   assign sdo_o    = sdo_q;
   assign sdo_oe_o = oe_q;
   assign data_o   = data_q;
   assign update_o = upd_q;
   assign err_o    = err_q;
   assign busy_o   = busy_q;

endmodule
